// File: rtl/replay_pkg.sv
// Shared types and width helpers for the replay buffer controller.
// Provides the FSM state enum and pointer/counter width functions.
package replay_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        REPLAY,
        HALT
    } state_t;

    localparam int DEF_ADDR_W = 2;

    // Pointers carry one wrap bit above the slot address.
    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/replay_timer.sv
// Ack timeout counter: counts while enabled, clears on clr or !en.
// Ports: clk, reset (sync, active-high), clr, en in; expired out.
module replay_timer
    import replay_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = cnt_width(TIMEOUT - 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr || !en) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

    assign expired = en && (r_cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/replay_ctrl.sv
// Replay buffer sequencer: write/transmit/ack pointers, nak/timeout replay, halt.
// Ports: clk, reset, wr, ack, nak, tx_rdy in; w_addr, r_addr, tx_valid,
//        full, empty, replaying, link_err, ack_err out.
module replay_ctrl
    import replay_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int TIMEOUT    = 16,
    parameter int MAX_REPLAY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              ack,
    input  logic              nak,
    input  logic              tx_rdy,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] r_addr,
    output logic              tx_valid,
    output logic              full,
    output logic              empty,
    output logic              replaying,
    output logic              link_err,
    output logic              ack_err
);

    localparam int PW = ptr_width(ADDR_W);
    localparam int CW = cnt_width(MAX_REPLAY);
    localparam logic [PW-1:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t         r_state;
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_tx_ptr;
    logic [PW-1:0]  r_ack_ptr;
    logic [PW-1:0]  r_rend;
    logic [CW-1:0]  r_rcnt;
    logic           r_ack_err;

    logic [PW-1:0]  w_unacked;
    logic [PW-1:0]  w_sent;
    logic           w_has_sent;
    logic           w_wr_ok;
    logic           w_ack_ok;
    logic           w_expired;
    logic           w_nak_eff;
    logic           w_rewind;
    logic           w_tx_ok;
    logic [PW-1:0]  w_nx_wr;
    logic [PW-1:0]  w_nx_ack;
    logic [PW-1:0]  w_nx_tx;
    logic [PW-1:0]  w_nx_rend;
    logic [CW-1:0]  w_nx_rcnt;
    state_t         w_nx_state;

    assign w_unacked  = r_wr_ptr - r_ack_ptr;
    assign w_sent     = r_tx_ptr - r_ack_ptr;
    assign w_has_sent = (w_sent != '0);

    assign full      = (w_unacked == DEPTH_P);
    assign empty     = (w_unacked == '0);
    assign w_addr    = r_wr_ptr[ADDR_W-1:0];
    assign r_addr    = r_tx_ptr[ADDR_W-1:0];
    assign tx_valid  = (r_tx_ptr != r_wr_ptr) && (r_state != HALT);
    assign replaying = (r_state == REPLAY);
    assign link_err  = (r_state == HALT);
    assign ack_err   = r_ack_err;

    assign w_wr_ok   = wr && !full;
    assign w_ack_ok  = ack && w_has_sent;
    assign w_nak_eff = nak || w_expired;
    assign w_rewind  = w_nak_eff && w_has_sent && (r_state != HALT);
    assign w_tx_ok   = tx_valid && tx_rdy && !w_nak_eff;

    assign w_nx_wr  = w_wr_ok ? r_wr_ptr + PTR_ONE : r_wr_ptr;
    assign w_nx_ack = w_ack_ok ? r_ack_ptr + PTR_ONE : r_ack_ptr;

    replay_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_ack_ok || w_rewind),
        .en      (w_has_sent && (r_state != HALT)),
        .expired (w_expired)
    );

    always_comb begin
        w_nx_tx    = r_tx_ptr;
        w_nx_rend  = r_rend;
        w_nx_rcnt  = r_rcnt;
        w_nx_state = r_state;
        if (w_ack_ok) begin
            w_nx_rcnt = '0;
        end
        if (w_rewind) begin
            w_nx_rcnt = w_nx_rcnt + CNT_ONE;
            // The halting replay keeps tx_ptr so late acks can still retire.
            if (w_nx_rcnt == CW'(MAX_REPLAY)) begin
                w_nx_state = HALT;
            end else begin
                w_nx_tx    = w_nx_ack;
                w_nx_rend  = r_tx_ptr;
                w_nx_state = REPLAY;
            end
        end else begin
            if (w_tx_ok) begin
                w_nx_tx = r_tx_ptr + PTR_ONE;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_wr_ok) w_nx_state = SEND;
                end
                SEND: begin
                    if (w_nx_wr == w_nx_ack) w_nx_state = IDLE;
                end
                REPLAY: begin
                    if (w_nx_tx == r_rend) begin
                        w_nx_state = (w_nx_wr == w_nx_ack) ? IDLE : SEND;
                    end
                end
                HALT: begin
                    w_nx_state = HALT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_wr_ptr  <= '0;
            r_tx_ptr  <= '0;
            r_ack_ptr <= '0;
            r_rend    <= '0;
            r_rcnt    <= '0;
            r_ack_err <= 1'b0;
        end else begin
            r_state   <= w_nx_state;
            r_wr_ptr  <= w_nx_wr;
            r_tx_ptr  <= w_nx_tx;
            r_ack_ptr <= w_nx_ack;
            r_rend    <= w_nx_rend;
            r_rcnt    <= w_nx_rcnt;
            r_ack_err <= ack && !w_has_sent;
        end
    end

endmodule
